// File: rtl/fault_capture_array.sv
// fault_capture_array: N-bit laser-target register with a protected golden
// shadow, per-bit debounced view, and an arm/fault FSM that detects,
// localises and counts bit upsets induced in the target during a shot.
module fault_capture_array #(
  parameter int unsigned N            = 8,
  parameter int unsigned DB_COUNT_MAX = 20000,
  parameter int unsigned DB_COUNT_N   = 15,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned IDX_W        = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N-1:0]     d,
  input  logic             arm,
  input  logic             clear,
  input  logic             mode_refresh,
  output logic [N-1:0]     q_db,
  output logic [1:0]       state,
  output logic             fault_any,
  output logic [N-1:0]     fault_map,
  output logic [CNT_W-1:0] fault_count,
  output logic [IDX_W-1:0] first_idx,
  output logic             first_valid
);

  localparam logic [CNT_W-1:0]      CNT_SAT = {CNT_W{1'b1}};
  localparam logic [DB_COUNT_N-1:0] DB_MAX  = DB_COUNT_N'(DB_COUNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_FAULTED = 2'd2
  } state_t;

  state_t st_q, st_d;

  // Target and golden shadow must stay physically distinct registers.
  (* keep = "true" *) logic [N-1:0] q;
  (* keep = "true" *) logic [N-1:0] g;
  logic [N-1:0] q_nxt, g_nxt;

  logic [N-1:0] mm;
  logic         mm_any;
  logic         mm_prev;
  logic         active;
  logic         fault_event;

  logic [DB_COUNT_N-1:0] db_cnt [N];

  // Lowest set bit of a mismatch vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign mm          = q ^ g;
  assign mm_any      = |mm;
  assign active      = (st_q != S_IDLE);
  assign fault_event = active && mm_any && !mm_prev;
  assign state       = st_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= S_IDLE;
    else          st_q <= st_d;
  end

  // FSM next state; clear wins over everything else.
  always_comb begin
    st_d = st_q;
    if (clear) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE:    if (arm) st_d = S_ARMED;
        S_ARMED:   if (fault_event) st_d = S_FAULTED;
        S_FAULTED: st_d = S_FAULTED;
        default:   st_d = S_IDLE;
      endcase
    end
  end

  // Target/shadow next value: load only in IDLE, optional heal once faulted.
  always_comb begin
    q_nxt = q;
    g_nxt = g;
    if (st_q == S_IDLE && en) begin
      q_nxt = d;
      g_nxt = d;
    end else if (st_q == S_FAULTED && mode_refresh && mm_any) begin
      q_nxt = g;
    end
  end

  // Target, shadow and previous-cycle mismatch flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      g       <= '0;
      mm_prev <= 1'b0;
    end else begin
      q       <= q_nxt;
      g       <= g_nxt;
      mm_prev <= mm_any;
    end
  end

  // Sticky fault record: map, saturating event count, first-fault locator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_any   <= 1'b0;
      fault_map   <= '0;
      fault_count <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else if (clear) begin
      fault_any   <= 1'b0;
      fault_map   <= '0;
      fault_count <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
    end else begin
      if (active) fault_map <= fault_map | mm;
      if (fault_event) begin
        fault_any <= 1'b1;
        if (fault_count != CNT_SAT) fault_count <= fault_count + CNT_W'(1);
        if (st_q == S_ARMED) begin
          first_idx   <= lowest_idx(mm);
          first_valid <= 1'b1;
        end
      end
    end
  end

  // Per-bit debounce: q_db follows q only after a persistent difference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_db <= '0;
      for (int i = 0; i < int'(N); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (q[i] == q_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          q_db[i]   <= q[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_COUNT_N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fault_capture_array.sv
// Scoreboard bench for fault_capture_array: the stimulus thread pushes
// hand-computed expected output snapshots, a negedge monitor pops and compares.
module tb_fault_capture_array;

  localparam int unsigned N     = 8;
  localparam int unsigned DB_MX = 4;
  localparam int unsigned DB_W  = 3;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [N-1:0]     d;
  logic             arm;
  logic             clear;
  logic             mode_refresh;
  logic [N-1:0]     q_db;
  logic [1:0]       state;
  logic             fault_any;
  logic [N-1:0]     fault_map;
  logic [CNT_W-1:0] fault_count;
  logic [IDX_W-1:0] first_idx;
  logic             first_valid;

  fault_capture_array #(
    .N(N), .DB_COUNT_MAX(DB_MX), .DB_COUNT_N(DB_W), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .d(d), .arm(arm), .clear(clear),
    .mode_refresh(mode_refresh), .q_db(q_db), .state(state),
    .fault_any(fault_any), .fault_map(fault_map), .fault_count(fault_count),
    .first_idx(first_idx), .first_valid(first_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [25:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Hand-maintained expected output state.
  logic [7:0] e_qdb;
  logic [1:0] e_state;
  logic       e_any;
  logic [7:0] e_map;
  logic [2:0] e_cnt;
  logic [2:0] e_idx;
  logic       e_fv;
  logic [7:0] frc_val;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string nm);
    exp_t e;
    e.name = nm;
    e.vec  = {e_qdb, e_state, e_any, e_map, e_cnt, e_idx, e_fv};
    sb_q.push_back(e);
  endtask

  task automatic clear_expect();
    e_state = 2'd0;
    e_any   = 1'b0;
    e_map   = 8'h00;
    e_cnt   = 3'd0;
    e_idx   = 3'd0;
    e_fv    = 1'b0;
  endtask

  // One-cycle upset on the target, then let heal/debounce settle.
  task automatic pulse(input logic [7:0] base, input logic [7:0] m);
    frc_val = base ^ m;
    force dut.q = frc_val;
    tick(1);
    release dut.q;
    tick(4);
  endtask

  // Monitor: compare every pending expectation away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [25:0] act;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {q_db, state, fault_any, fault_map, fault_count, first_idx, first_valid};
      n_checks++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got qdb=%h st=%0d any=%0b map=%h cnt=%0d idx=%0d fv=%0b, want qdb=%h st=%0d any=%0b map=%h cnt=%0d idx=%0d fv=%0b",
                 e.name, act[25:18], act[17:16], act[15], act[14:7], act[6:4], act[3:1], act[0],
                 e.vec[25:18], e.vec[17:16], e.vec[15], e.vec[14:7], e.vec[6:4], e.vec[3:1], e.vec[0]);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    reset_n = 1'b0;
    en = 1'b0; d = '0; arm = 1'b0; clear = 1'b0; mode_refresh = 1'b0;
    frc_val = 8'h00;
    e_qdb = 8'h00;
    clear_expect();

    tick(2);
    expect_out("reset_init");
    tick(1);
    reset_n = 1'b1;

    // Load 0xA5; q_db follows on the 6th edge.
    en = 1'b1; d = 8'hA5;
    tick(1);
    en = 1'b0;
    tick(4);
    expect_out("db_before");
    tick(1);
    e_qdb = 8'hA5;
    expect_out("db_after");

    // Two-cycle glitch on q[0] in IDLE.
    frc_val = 8'hA4;
    force dut.q = frc_val;
    tick(2);
    release dut.q;
    frc_val = 8'hA5;
    force dut.q = frc_val;
    tick(1);
    release dut.q;
    tick(8);
    expect_out("glitch_idle");

    // Arm, upset q[3] with refresh off.
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    e_state = 2'd1;
    expect_out("armed");
    frc_val = 8'hAD;
    force dut.q = frc_val;
    tick(1);
    release dut.q;
    e_state = 2'd2; e_any = 1'b1; e_map = 8'h08; e_cnt = 3'd1; e_idx = 3'd3; e_fv = 1'b1;
    expect_out("first_fault");
    tick(8);
    e_qdb = 8'hAD;
    expect_out("hold_faulty");
    en = 1'b1; d = 8'h00;
    tick(1);
    en = 1'b0;
    tick(8);
    expect_out("en_ignored");

    // clear beats arm.
    clear = 1'b1; arm = 1'b1;
    tick(1);
    clear = 1'b0; arm = 1'b0;
    clear_expect();
    expect_out("clear_arm");

    // Reload, arm, healing pulses on bits 6 and 1.
    en = 1'b1; d = 8'hA5;
    tick(1);
    en = 1'b0;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    mode_refresh = 1'b1;
    e_state = 2'd1;
    expect_out("rearmed");
    e_qdb = 8'hA5;
    pulse(8'hA5, 8'h40);
    e_state = 2'd2; e_any = 1'b1; e_map = 8'h40; e_cnt = 3'd1; e_idx = 3'd6; e_fv = 1'b1;
    expect_out("heal_1");
    pulse(8'hA5, 8'h02);
    e_map = 8'h42; e_cnt = 3'd2;
    expect_out("heal_2");
    pulse(8'hA5, 8'h40);
    e_cnt = 3'd3;
    expect_out("heal_3");
    for (int k = 0; k < 4; k++) pulse(8'hA5, (k % 2 == 0) ? 8'h02 : 8'h40);
    e_cnt = 3'd7;
    expect_out("count_7");
    pulse(8'hA5, 8'h02);
    pulse(8'hA5, 8'h40);
    expect_out("saturated");

    // Clear, rebuild a count of 2, then async reset mid-cycle.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    clear_expect();
    expect_out("clear_2");
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    pulse(8'hA5, 8'h40);
    pulse(8'hA5, 8'h02);
    e_state = 2'd2; e_any = 1'b1; e_map = 8'h42; e_cnt = 3'd2; e_idx = 3'd6; e_fv = 1'b1;
    expect_out("pre_reset");
    tick(1);
    #1;
    reset_n = 1'b0;
    #1;
    e_qdb = 8'h00;
    clear_expect();
    expect_out("async_reset");
    tick(2);
    reset_n = 1'b1;

    // Drain outstanding expectations with a bounded wait.
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick(1);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_capture_array.md
Name: fault_capture_array

Overview:
- Parametrised successor to the laser-target flip-flop bank: an N-bit target register with a protected golden shadow copy.
- Per-bit debounced outputs.
- An arm/fault state machine that detects, localises and counts bit upsets induced in the target register during a laser shot.
- Sits behind the board clock wizard; outputs drive LEDs/GPIO or a UART status reporter.

Parameters:
- N, 8, target register width in bits (N >= 2).
- DB_COUNT_MAX, 20000, cycles a q/q_db difference must persist before q_db follows.
- DB_COUNT_N, 15, debounce counter width; must hold DB_COUNT_MAX.
- CNT_W, 8, fault event counter width.
- IDX_W, 3, bit-index width; must equal clog2(N).

Ports:
- clk  in  1  system clock (100 MHz from clock wizard)
- reset_n  in  1  asynchronous active-low reset
- en  in  1  write enable for target and shadow (IDLE only)
- d  in  N  write data
- arm  in  1  pulse: IDLE -> ARMED
- clear  in  1  pulse: any state -> IDLE, clears fault record
- mode_refresh  in  1  1 = heal target from shadow after a fault; 0 = hold faulty value
- q_db  out  N  debounced target value
- state  out  2  0 IDLE, 1 ARMED, 2 FAULTED
- fault_any  out  1  sticky, 1 once any fault recorded
- fault_map  out  N  sticky OR of all mismatching bits since clear
- fault_count  out  CNT_W  saturating count of fault events
- first_idx  out  IDX_W  lowest mismatching bit index of first fault event
- first_valid  out  1  first_idx valid

Behaviour:
- Reset (reset_n = 0, asynchronous): all outputs 0; q, g, debounce counters and mismatch history 0; state IDLE.
- Target q and shadow g are separate registers. Both carry keep attributes so synthesis does not merge them.
- IDLE:
  - en = 1: q <= d and g <= d, same cycle.
  - arm = 1 (clear = 0): ARMED next cycle.
- ARMED/FAULTED: en is ignored; q and g hold except for heal.
- Mismatch: mm = q ^ g, evaluated every cycle.
- A fault event is a cycle where mm != 0 and the previous cycle's mm == 0. Events are recognised in ARMED and FAULTED only; mm is ignored in IDLE.
- On each event, registered with one cycle latency:
  - fault_count increments, saturating at 2^CNT_W-1.
  - fault_any <= 1.
- Every cycle in ARMED/FAULTED: fault_map <= fault_map | mm. Bits added during a persisting mismatch are also captured.
- First event while ARMED:
  - first_idx <= index of lowest set bit of mm.
  - first_valid <= 1.
  - State -> FAULTED.
- FAULTED with mode_refresh = 1: q <= g on the cycle after mm != 0 is seen. mm returns to 0, so a later flip counts as a new event.
- FAULTED with mode_refresh = 0: q holds its faulty value; no further events until mm returns to 0.
- clear = 1:
  - State -> IDLE.
  - fault_map, fault_count, fault_any, first_idx, first_valid -> 0.
  - q and g unchanged.
  - clear beats arm and event updates in the same cycle.
- Debounce, per bit i, independent:
  - If q[i] == q_db[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_COUNT_MAX: q_db[i] <= q[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - Result: a stable change reaches q_db after DB_COUNT_MAX+1 cycles. A glitch shorter than that never reaches q_db.
- state output is the registered FSM state; no combinational paths from inputs to outputs.

Test Plan (bench uses N=8, DB_COUNT_MAX=4, CNT_W=3):
- Reset asserted mid-operation (state FAULTED, count 2) -> all outputs 0 and state IDLE immediately, before the next clk edge.
- IDLE, en=1, d=0xA5 for one cycle -> q_db=0xA5 exactly 6 cycles later; state stays 0; fault_any=0.
- Write 0xA5, arm, force q[3] flipped, mode_refresh=0 -> next cycle: fault_map=0x08, first_idx=3, first_valid=1, fault_count=1, state=2. Release force -> q stays 0xAD and count stays 1. en=1 d=0x00 while FAULTED -> q unchanged.
- mode_refresh=1, force q[6] and q[1] flips in 3 separate pulses -> q heals to g after each; fault_map=0x42; fault_count=3; first_idx from first pulse. Total 9 pulses -> fault_count saturates at 7.
- 2-cycle glitch on q[0] in IDLE -> q_db unchanged; no fault recorded (IDLE).
- clear and arm asserted together in FAULTED -> state IDLE, all fault outputs 0, q_db unchanged.
